pipeline_ctrl: RTL and testbench

// - Central sequencer for the 5-stage ARM pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Produces freeze (hold) and flush (clr) controls from load-use hazards, taken branches and the SRAM ready handshake.
// - Keeps saturating stall and flush event counters plus a sticky memory-timeout flag for debug.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared constants and state encoding for the pipeline sequencer
package pipeline_ctrl_pkg;

  localparam int DEF_RF_ADDR_W   = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 63;

  typedef enum logic {
    STATE_RUN      = 1'b0,
    STATE_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - event counter with sync clear that sticks at all-ones
module pipeline_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - freeze/flush sequencer for the 5-stage pipeline registers
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W   = DEF_RF_ADDR_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 forward_en,
  input  logic [RF_ADDR_W-1:0] id_src1,
  input  logic [RF_ADDR_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic                 id_has_src1,
  input  logic [RF_ADDR_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [RF_ADDR_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 b_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 cnt_clr,
  output logic                 freeze_if,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 freeze_all,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              timeout_nx;
  logic              exe_qual, mem_qual;
  logic              src1_hit, src2_hit, hazard;

  // With forwarding, only a load in EX cannot be bypassed; MEM results always can.
  assign exe_qual = exe_wb_en & (~forward_en | exe_mem_r_en);
  assign mem_qual = mem_wb_en & ~forward_en;

  assign src1_hit = ((exe_dest == id_src1) & exe_qual) | ((mem_dest == id_src1) & mem_qual);
  assign src2_hit = ((exe_dest == id_src2) & exe_qual) | ((mem_dest == id_src2) & mem_qual);
  assign hazard   = (id_has_src1 & src1_hit) | (id_two_src & src2_hit);

  always_comb begin
    state_nx    = state;
    wait_nx     = wait_cnt;
    timeout_nx  = mem_timeout;
    freeze_all  = 1'b0;
    freeze_if   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;

    case (state)
      STATE_RUN: begin
        freeze_all = mem_req & ~mem_ready;
        if (freeze_all) state_nx = STATE_MEM_WAIT;
      end
      STATE_MEM_WAIT: begin
        if (mem_ready) begin
          state_nx = STATE_RUN;
          wait_nx  = '0;
        end else begin
          freeze_all = 1'b1;
          if (wait_cnt != WAIT_MAX) wait_nx = wait_cnt + 1'b1;
          if (wait_nx == WAIT_MAX) timeout_nx = 1'b1;
        end
      end
      default: state_nx = STATE_RUN;
    endcase

    // A pending branch or hazard simply waits out the memory freeze.
    if (freeze_all) begin
      freeze_if = 1'b1;
    end else if (b_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      freeze_if   = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STATE_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      mem_timeout <= timeout_nx;
    end
  end

  pipeline_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (freeze_if | freeze_all),
    .q   (stall_cnt)
  );

  pipeline_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (flush_if_id),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector and sequence checks for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_two_src, id_has_src1, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic        b_taken, mem_req, mem_ready, cnt_clr;
  logic        freeze_if, flush_if_id, flush_id_ex, freeze_all, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .forward_en   (forward_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_has_src1  (id_has_src1),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .b_taken      (b_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .cnt_clr      (cnt_clr),
    .freeze_if    (freeze_if),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .freeze_all   (freeze_all),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .mem_timeout  (mem_timeout)
  );

  typedef struct {
    string      name;
    logic       fwd;
    logic [3:0] s1, s2;
    logic       two, has1;
    logic [3:0] ed;
    logic       ewb, emr;
    logic [3:0] md;
    logic       mwb, bt, mreq, mrdy;
    logic [3:0] exp_ctl;  // {freeze_if, flush_if_id, flush_id_ex, freeze_all}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_has_src1 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    b_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_hazard(input logic fwd);
    forward_en = fwd; id_src1 = 4'd3; id_has_src1 = 1; exe_dest = 4'd3; exe_wb_en = 1;
  endtask

  function automatic logic [3:0] ctl();
    return {freeze_if, flush_if_id, flush_id_ex, freeze_all};
  endfunction

  initial begin
    int n;
    //          name          fwd s1 s2 two has1 ed ewb emr md mwb bt mreq mrdy exp
    vecs[0]  = '{"idle",       0, 0, 0, 0, 0,   0, 0,  0,  0, 0,  0, 0,   0,   4'b0000};
    vecs[1]  = '{"ex_nofwd",   0, 3, 0, 0, 1,   3, 1,  0,  0, 0,  0, 0,   0,   4'b1010};
    vecs[2]  = '{"ex_fwd_alu", 1, 3, 0, 0, 1,   3, 1,  0,  0, 0,  0, 0,   0,   4'b0000};
    vecs[3]  = '{"ex_fwd_ld",  1, 3, 0, 0, 1,   3, 1,  1,  0, 0,  0, 0,   0,   4'b1010};
    vecs[4]  = '{"mem_nofwd",  0, 0, 5, 1, 0,   0, 0,  0,  5, 1,  0, 0,   0,   4'b1010};
    vecs[5]  = '{"mem_fwd",    1, 0, 5, 1, 0,   0, 0,  0,  5, 1,  0, 0,   0,   4'b0000};
    vecs[6]  = '{"src2_unused",0, 0, 5, 0, 0,   0, 0,  0,  5, 1,  0, 0,   0,   4'b0000};
    vecs[7]  = '{"src1_unused",0, 3, 0, 0, 0,   3, 1,  0,  0, 0,  0, 0,   0,   4'b0000};
    vecs[8]  = '{"ex_no_wb",   0, 3, 0, 0, 1,   3, 0,  0,  0, 0,  0, 0,   0,   4'b0000};
    vecs[9]  = '{"br_over_hz", 0, 3, 0, 0, 1,   3, 1,  0,  0, 0,  1, 0,   0,   4'b0110};
    vecs[10] = '{"mem_over_br",0, 3, 0, 0, 1,   3, 1,  0,  0, 0,  1, 1,   0,   4'b1001};
    vecs[11] = '{"mem_rdy_hz", 0, 3, 0, 0, 1,   3, 1,  0,  0, 0,  0, 1,   1,   4'b1010};
    vecs[12] = '{"dest_diff",  0, 3, 0, 0, 1,   4, 1,  0,  4, 1,  0, 0,   0,   4'b0000};

    set_idle();
    cnt_clr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl()), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    chk("reset_timeout", 32'(mem_timeout), 0);
    rst = 0;

    // Table: combinational controls from RUN; inputs idled before each edge so state stays RUN.
    foreach (vecs[i]) begin
      @(negedge clk);
      forward_en = vecs[i].fwd; id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
      id_two_src = vecs[i].two; id_has_src1 = vecs[i].has1; exe_dest = vecs[i].ed;
      exe_wb_en = vecs[i].ewb; exe_mem_r_en = vecs[i].emr; mem_dest = vecs[i].md;
      mem_wb_en = vecs[i].mwb; b_taken = vecs[i].bt; mem_req = vecs[i].mreq;
      mem_ready = vecs[i].mrdy;
      #1;
      chk(vecs[i].name, 32'(ctl()), 32'(vecs[i].exp_ctl));
      set_idle();
    end

    // One-cycle load-use stall counts once.
    @(negedge clk); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0; set_hazard(0);
    @(negedge clk); set_idle();
    chk("stall_one", 32'(stall_cnt), 1);
    chk("flush_zero", 32'(flush_cnt), 0);

    // Taken branch beats a concurrent hazard.
    set_hazard(0); b_taken = 1;
    @(negedge clk); set_idle();
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 1);

    // Memory wait of 4 cycles with branch held: flush only once ready arrives.
    cnt_clr = 1;
    @(negedge clk); cnt_clr = 0;
    mem_req = 1; b_taken = 1; n = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (freeze_all) n++;
      chk("mw_no_flush", 32'(flush_if_id), 0);
      @(negedge clk);
    end
    mem_ready = 1;
    #1;
    chk("mw_freeze_cycles", 32'(n), 4);
    chk("mw_ready_ctl", 32'(ctl()), 32'(4'b0110));
    @(negedge clk); set_idle();
    #1;
    chk("mw_back_run", 32'(ctl()), 0);
    chk("mw_stall_cnt", 32'(stall_cnt), 4);
    chk("mw_flush_cnt", 32'(flush_cnt), 1);

    // Timeout: sets when wait_cnt reaches 63, i.e. on the 64th edge after the request.
    @(negedge clk); mem_req = 1;
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("to_before", 32'(mem_timeout), 0);
    @(negedge clk);
    chk("to_set", 32'(mem_timeout), 1);
    repeat (6) @(negedge clk);
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_still_frozen", 32'(freeze_all), 1);
    rst = 1;
    #1;
    chk("to_rst_clears", 32'(mem_timeout), 0);
    mem_req = 0;
    #1;
    chk("rst_back_run", 32'(freeze_all), 0);
    @(negedge clk); rst = 0;

    // Saturation, then clear wins over a same-cycle increment.
    set_hazard(0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    cnt_clr = 1;
    @(negedge clk);
    chk("clr_wins", 32'(stall_cnt), 0);
    chk("clr_ctl_kept", 32'(ctl()), 32'(4'b1010));
    cnt_clr = 0; set_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
